// File: rtl/sw_event_gen_if.sv
// Pin-side and event-side signals of the switch conditioning stage.
// master = pin/consumer side, slave = sw_event_gen.
interface sw_event_gen_if #(
  parameter int N_SW = 4
);
  logic [N_SW-1:0] i_sw;
  logic [N_SW-1:0] o_level;
  logic [N_SW-1:0] o_press;
  logic [N_SW-1:0] o_release;
  logic [N_SW-1:0] o_long;
  logic [N_SW-1:0] o_rpt;

  modport master (output i_sw, input o_level, o_press, o_release, o_long, o_rpt);
  modport slave  (input i_sw, output o_level, o_press, o_release, o_long, o_rpt);
endinterface

// File: rtl/sw_event_gen.sv
// Debounces N_SW active-low buttons into clean levels plus press/release/long/repeat pulses.
// Auto-repeat pulses on o_rpt exist only when SW_AUTO_REPEAT_EN is defined.
module sw_event_gen #(
  parameter int N_SW     = 4,
  parameter int DEB_CYC  = 500000,
  parameter int LONG_CYC = 50000000,
  parameter int RPT_CYC  = 10000000
) (
  input  logic          clk,
  input  logic          rst,
  sw_event_gen_if.slave sw
);

  typedef enum logic [1:0] {ST_REL, ST_PRS, ST_LNG} state_e;

  // A misconfigured instance never accepts a level change rather than misbehaving.
  localparam bit          CFG_OK    = (DEB_CYC >= 1) && (LONG_CYC >= 1) && (RPT_CYC >= 1);
  localparam logic [31:0] DEB_LAST  = 32'(DEB_CYC - 1);
  localparam logic [31:0] LONG_LAST = 32'(LONG_CYC - 1);
`ifdef SW_AUTO_REPEAT_EN
  localparam logic [31:0] RPT_LAST  = 32'(RPT_CYC - 1);
`endif

  logic [N_SW-1:0] level_w, press_w, release_w, long_w, rpt_w;

  for (genvar gi = 0; gi < N_SW; gi++) begin : g_ch
    logic        sync1_q, sync2_q;
    logic        s, level, accept;
    logic [31:0] deb_cnt_q, deb_cnt_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    state_e      state_q, state_d;
    logic        press_q, press_d, release_q, release_d, long_q, long_d;
`ifdef SW_AUTO_REPEAT_EN
    logic [31:0] rpt_cnt_q, rpt_cnt_d;
    logic        rpt_q, rpt_d;
`endif

    assign s     = ~sync2_q;
    assign level = (state_q != ST_REL);

    // Any cycle where the synchronized pin agrees with the level restarts the count.
    always_comb begin
      deb_cnt_d = '0;
      accept    = 1'b0;
      if (s != level) begin
        if (deb_cnt_q == DEB_LAST) begin
          accept = CFG_OK;
        end else begin
          deb_cnt_d = deb_cnt_q + 32'd1;
        end
      end
    end

    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;
`ifdef SW_AUTO_REPEAT_EN
      rpt_cnt_d  = rpt_cnt_q;
      rpt_d      = 1'b0;
`endif
      case (state_q)
        ST_REL: begin
          if (accept) begin
            press_d    = 1'b1;
            hold_cnt_d = '0;
            state_d    = ST_PRS;
          end
        end
        ST_PRS: begin
          // Release is tested first so it wins over a coincident long-press.
          if (accept) begin
            release_d = 1'b1;
            state_d   = ST_REL;
          end else if (hold_cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            state_d = ST_LNG;
`ifdef SW_AUTO_REPEAT_EN
            rpt_cnt_d = '0;
            rpt_d     = 1'b1;
`endif
          end else begin
            hold_cnt_d = hold_cnt_q + 32'd1;
          end
        end
        ST_LNG: begin
          if (accept) begin
            release_d = 1'b1;
            state_d   = ST_REL;
          end
`ifdef SW_AUTO_REPEAT_EN
          else if (rpt_cnt_q == RPT_LAST) begin
            rpt_cnt_d = '0;
            rpt_d     = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 32'd1;
          end
`endif
        end
        default: state_d = ST_REL;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q    <= 1'b1;
        sync2_q    <= 1'b1;
        deb_cnt_q  <= '0;
        hold_cnt_q <= '0;
        state_q    <= ST_REL;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
`ifdef SW_AUTO_REPEAT_EN
        rpt_cnt_q  <= '0;
        rpt_q      <= 1'b0;
`endif
      end else begin
        sync1_q    <= sw.i_sw[gi];
        sync2_q    <= sync1_q;
        deb_cnt_q  <= deb_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        state_q    <= state_d;
        press_q    <= press_d;
        release_q  <= release_d;
        long_q     <= long_d;
`ifdef SW_AUTO_REPEAT_EN
        rpt_cnt_q  <= rpt_cnt_d;
        rpt_q      <= rpt_d;
`endif
      end
    end

    assign level_w[gi]   = level;
    assign press_w[gi]   = press_q;
    assign release_w[gi] = release_q;
    assign long_w[gi]    = long_q;
`ifdef SW_AUTO_REPEAT_EN
    assign rpt_w[gi]     = rpt_q;
`else
    assign rpt_w[gi]     = 1'b0;
`endif
  end

  assign sw.o_level   = level_w;
  assign sw.o_press   = press_w;
  assign sw.o_release = release_w;
  assign sw.o_long    = long_w;
  assign sw.o_rpt     = rpt_w;

endmodule
